// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_queue_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    localparam logic [INST_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] instr;
    } fq_entry_t;

    localparam int unsigned ENTRY_W = $bits(fq_entry_t);

    // IDLE: nothing in flight; BUSY: one request in flight; DROP: in flight, response to be discarded
    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_BUSY = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and IF-ID facing signals of the fetch queue.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] npc_out;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, pc_out, npc_out,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, pc_out, npc_out,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with flush; head data is visible combinationally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             rd_en_c;
    logic             wr_en_c;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign rd_en_c = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign wr_en_c = push_i & (~full_o | rd_en_c);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en_c && !rd_en_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (rd_en_c && !wr_en_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one request at a time and
// buffers returned instructions for IF-ID, honouring stall and redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = FQ_DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);

    localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fq_state_e         state_q;
    fq_state_e         state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic [ADDR_W-1:0] req_pc_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head_raw;
    fq_entry_t          head_c;
    fq_entry_t          push_entry_c;

    logic pop_now_c;
    logic room_c;
    logic pop_c;
    logic issue_c;
    logic push_c;

    // Issue needs room counting the head that is about to be popped this cycle
    assign pop_now_c = bus.inst_valid & ~bus.stall;
    assign room_c    = (32'(fifo_count) + 32'(pop_now_c)) < DEPTH;
    assign pop_c     = pop_now_c & ~bus.redirect;

    assign push_entry_c.pc    = req_pc_q;
    assign push_entry_c.instr = bus.imem_rdata;
    assign head_c             = fq_entry_t'(fifo_head_raw);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .data_i  (push_entry_c),
        .pop_i   (pop_c),
        .flush_i (bus.redirect),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head_raw)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FQ_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Request tracking; redirect overrides the PC and turns an in-flight request into a drop
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        issue_c    = 1'b0;
        push_c     = 1'b0;

        unique case (state_q)
            FQ_IDLE: begin
                if (!rst_i && !bus.redirect && room_c) begin
                    issue_c    = 1'b1;
                    state_d    = FQ_BUSY;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            FQ_BUSY: begin
                if (bus.imem_ack) begin
                    state_d = FQ_IDLE;
                    push_c  = ~bus.redirect;
                end else if (bus.redirect) begin
                    state_d = FQ_DROP;
                end
            end
            FQ_DROP: begin
                if (bus.imem_ack) begin
                    state_d = FQ_IDLE;
                end
            end
            default: state_d = FQ_IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end
    end

    assign bus.imem_req   = issue_c;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = ~fifo_empty;
    assign bus.inst_out   = fifo_empty ? NOP_INSTR : head_c.instr;
    assign bus.pc_out     = fifo_empty ? '0 : head_c.pc;
    assign bus.npc_out    = fifo_empty ? '0 : head_c.pc + PC_STEP;

    // Issue reserves a slot, so a push can never land on a full FIFO without a pop
    assert property (@(posedge clk_i) disable iff (rst_i) push_c |-> (!fifo_full || pop_c));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a variable-latency memory model.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if bus();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // memory model state
    int          mem_lat = 1;
    int          cd      = 0;
    bit          mem_en  = 1'b1;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic v, input logic [31:0] pc);
        check32({name, ".valid"}, 32'(bus.inst_valid), 32'(v));
        check32({name, ".pc"}, bus.pc_out, v ? pc : 32'h0);
        check32({name, ".npc"}, bus.npc_out, v ? pc + 32'd4 : 32'h0);
        check32({name, ".inst"}, bus.inst_out, v ? instr_of(pc) : 32'h0);
    endtask

    // capture requests mid-cycle, respond mem_lat cycles later
    always @(negedge clk) begin
        if (mem_en && !rst && bus.imem_req) begin
            pend_addr = bus.imem_addr;
            cd        = mem_lat;
        end
    end

    always @(posedge clk) begin
        #2;
        if (mem_en) begin
            bus.imem_ack = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = instr_of(pend_addr);
                end
            end
        end
    end

    task automatic do_reset(input int lat);
        rst             = 1'b1;
        mem_en          = 1'b1;
        mem_lat         = lat;
        cd              = 0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        int   nreq;
        int   npop;
        bit   seen;
        bit   done;

        // 1-cycle memory, short stall window in the middle
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 32'h08, 1'b0, 32'h00};
        vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5]  = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h00};
        vecs[6]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        vecs[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[8]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[9]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
        vecs[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
        vecs[11] = '{1'b0, 1'b0, 32'h18, 1'b0, 32'h00};

        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // reset state
        @(negedge clk);
        check32("rst.req", 32'(bus.imem_req), 32'h0);
        check32("rst.addr", bus.imem_addr, 32'h0);
        check_head("rst", 1'b0, 32'h0);

        // table-driven streaming
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            bus.stall = vecs[i].stall;
            @(negedge clk);
            check32($sformatf("vec%0d.req", i), 32'(bus.imem_req), 32'(vecs[i].req));
            check32($sformatf("vec%0d.addr", i), bus.imem_addr, vecs[i].addr);
            check_head($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc);
            next_cycle();
        end

        // latency 3 with stall held: fill to DEPTH then stop issuing
        do_reset(3);
        bus.stall = 1'b1;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                check32($sformatf("full.req%0d.addr", nreq), bus.imem_addr, 32'(nreq * 4));
                nreq++;
            end
            next_cycle();
        end
        @(negedge clk);
        check32("full.nreq", 32'(nreq), 32'd4);
        check32("full.req_after", 32'(bus.imem_req), 32'h0);
        check32("full.addr", bus.imem_addr, 32'h10);
        check_head("full.head", 1'b1, 32'h0);
        next_cycle();
        bus.stall = 1'b0;
        npop = 0;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (bus.imem_req && !seen) begin
                check32("drain.resume_addr", bus.imem_addr, 32'h10);
                seen = 1'b1;
            end
            if (bus.inst_valid && npop < 4) begin
                check_head($sformatf("drain%0d", npop), 1'b1, 32'(npop * 4));
                npop++;
            end
            done = seen && (npop >= 4);
            next_cycle();
        end
        check32("drain.done", 32'(done), 32'h1);

        // redirect with a request to 0x8 in flight (latency 2), FIFO non-empty under stall
        do_reset(2);
        bus.stall = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = bus.imem_req && (bus.imem_addr == 32'h8);
            next_cycle();
        end
        check32("redir.saw_req8", 32'(done), 32'h1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check32("redir.no_issue", 32'(bus.imem_req), 32'h0);
        check32("redir.head_before", bus.pc_out, 32'h0);
        next_cycle();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        @(negedge clk);
        check_head("redir.flushed", 1'b0, 32'h0);
        next_cycle();
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.imem_req && !seen) begin
                check32("redir.first_addr", bus.imem_addr, 32'h100);
                seen = 1'b1;
            end
            if (bus.inst_valid) begin
                check_head("redir.first_valid", 1'b1, 32'h100);
                done = 1'b1;
            end
            next_cycle();
        end
        check32("redir.got_valid", 32'(done), 32'h1);

        // redirect in the same cycle as the ack; unaligned target
        do_reset(1);
        bus.stall = 1'b1;
        @(negedge clk);
        check32("same.req0", 32'(bus.imem_req), 32'h1);
        next_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        @(negedge clk);
        check32("same.no_issue", 32'(bus.imem_req), 32'h0);
        next_cycle();
        bus.redirect = 1'b0;
        @(negedge clk);
        check_head("same.dropped", 1'b0, 32'h0);
        check32("same.req", 32'(bus.imem_req), 32'h1);
        check32("same.addr", bus.imem_addr, 32'h200);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check_head("same.target", 1'b1, 32'h200);

        // reset while a request is outstanding, stale ack afterwards
        do_reset(1);
        mem_en = 1'b0;
        @(negedge clk);
        check32("mid.req0", 32'(bus.imem_req), 32'h1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check32("mid.rst_req", 32'(bus.imem_req), 32'h0);
        check32("mid.rst_addr", bus.imem_addr, 32'h0);
        check_head("mid.rst", 1'b0, 32'h0);
        next_cycle();
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check32("mid.post_req", 32'(bus.imem_req), 32'h1);
        check32("mid.post_addr", bus.imem_addr, 32'h0);
        next_cycle();
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check_head("mid.stale_ignored", 1'b0, 32'h0);
        next_cycle();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr_of(32'h0);
        next_cycle();
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check_head("mid.real", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
